// File: rtl/vector_finish_tracker_pkg.sv
// vector_finish_tracker_pkg: shared state type, op encodings and default sizes
package vector_finish_tracker_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    localparam logic OP_DOWN = 1'b0;
    localparam logic OP_UP = 1'b1;
    localparam int DEF_N = 6;
    localparam int DEF_LANES = 4;
endpackage

// File: rtl/vector_finish_tracker_lane_mask_gen.sv
// vector_finish_tracker_lane_mask_gen: remaining element count to thermometer lane mask
module vector_finish_tracker_lane_mask_gen
    import vector_finish_tracker_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int LANES = DEF_LANES
) (
    input  logic [N:0]       i_remaining,
    output logic [LANES-1:0] o_mask
);
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign o_mask[i] = i_remaining > (N+1)'(i);
    end
endmodule

// File: rtl/vector_finish_tracker.sv
// vector_finish_tracker: walks a vector in LANES-wide beats and raises a sticky finished flag
module vector_finish_tracker
    import vector_finish_tracker_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int LANES = DEF_LANES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [N-1:0]     i_vector_len,
    input  logic             i_op_type,
    input  logic             i_stall,
    input  logic             i_abort,
    input  logic             i_ack,
    output logic [N-1:0]     o_counter,
    output logic             o_beat_valid,
    output logic [LANES-1:0] o_lane_mask,
    output logic             o_busy,
    output logic             o_finished,
    output logic             o_done_pulse
);
    localparam logic [N:0] L = (N+1)'(LANES);
    state_t r_state;
    logic [N-1:0] r_counter, r_len;
    logic r_op, r_finished, r_done_pulse;
    logic [N:0] w_remaining, w_sum;
    logic [N-1:0] w_next;
    logic w_last;
    logic [LANES-1:0] w_mask;
    // one extra bit keeps the up-count sum from wrapping at vector_len = 2^N-1
    assign w_remaining = r_op ? {1'b0, r_len} - {1'b0, r_counter} : {1'b0, r_counter};
    assign w_sum = {1'b0, r_counter} + L;
    assign w_next = r_op ? (w_sum >= {1'b0, r_len} ? r_len : w_sum[N-1:0])
                         : (w_remaining <= L ? '0 : r_counter - L[N-1:0]);
    assign w_last = w_remaining <= L;
    vector_finish_tracker_lane_mask_gen #(.N(N), .LANES(LANES)) u_mask (
        .i_remaining(w_remaining),
        .o_mask(w_mask)
    );
    assign o_beat_valid = r_state == S_RUN;
    assign o_busy = r_state == S_RUN;
    assign o_lane_mask = o_beat_valid ? w_mask : '0;
    assign o_counter = r_counter;
    assign o_finished = r_finished;
    assign o_done_pulse = r_done_pulse;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_counter <= '0;
            r_len <= '0;
            r_op <= OP_DOWN;
            r_finished <= 1'b0;
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                        r_counter <= '0;
                    end else if (!i_stall) begin
                        r_counter <= w_next;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_finished <= 1'b1;
                            r_done_pulse <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (i_start) begin
                        r_len <= i_vector_len;
                        r_op <= i_op_type;
                        r_counter <= i_op_type == OP_UP ? '0 : i_vector_len;
                        r_state <= i_vector_len == '0 ? S_DONE : S_RUN;
                        r_finished <= i_vector_len == '0;
                        r_done_pulse <= i_vector_len == '0;
                    end else if (r_state == S_DONE && i_ack) begin
                        r_state <= S_IDLE;
                        r_finished <= 1'b0;
                        r_counter <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vector_finish_tracker.sv
// tb_vector_finish_tracker: random operations scored against a beat-list model of the tracker
module tb_vector_finish_tracker;
    localparam int N = 6;
    localparam int LANES = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, op_type = 1'b0, stall = 1'b0, abort = 1'b0, ack = 1'b0;
    logic [N-1:0] vector_len = '0;
    logic [N-1:0] o_counter;
    logic [LANES-1:0] o_lane_mask;
    logic o_beat_valid, o_busy, o_finished, o_done_pulse;

    typedef struct {bit done; int cnt; int mask;} exp_t;
    exp_t q[$];
    exp_t m_e;
    int n_checks = 0, n_fail = 0;
    bit p_bv = 0, p_stall = 0;
    int p_cnt = 0;

    vector_finish_tracker #(.N(N), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_vector_len(vector_len),
        .i_op_type(op_type), .i_stall(stall), .i_abort(abort), .i_ack(ack),
        .o_counter(o_counter), .o_beat_valid(o_beat_valid), .o_lane_mask(o_lane_mask),
        .o_busy(o_busy), .o_finished(o_finished), .o_done_pulse(o_done_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT output with no matching expectation at %0t", name, $time);
    endtask

    // monitor: every accepted beat and every done pulse consumes one scoreboard entry
    always @(negedge clk) begin
        if (rst_n) begin
            if (!o_beat_valid) chk("idle_mask", int'(o_lane_mask), 0);
            if (o_beat_valid && !stall && !abort) begin
                if (q.size() == 0 || q[0].done) unexpected("beat");
                else begin
                    m_e = q.pop_front();
                    chk("beat_counter", int'(o_counter), m_e.cnt);
                    chk("beat_mask", int'(o_lane_mask), m_e.mask);
                end
            end
            if (o_beat_valid && p_bv && p_stall) chk("stall_hold", int'(o_counter), p_cnt);
            if (o_done_pulse) begin
                if (q.size() == 0 || !q[0].done) unexpected("done_pulse");
                else begin
                    m_e = q.pop_front();
                    chk("done_finished", int'(o_finished), 1);
                end
            end
            p_bv = o_beat_valid;
            p_stall = stall && !abort;
            p_cnt = int'(o_counter);
        end else p_bv = 0;
    end

    task automatic run_op(input int len, input bit op, input int abort_at, input bit use_ack, input int pct);
        int nb, acc, cyc, stc, c, rem;
        bit aborted;
        nb = 0; acc = 0; cyc = 0; stc = 0;
        c = op ? 0 : len;
        while ((op ? len - c : c) > 0) begin
            rem = op ? len - c : c;
            if (abort_at < 0 || nb < abort_at)
                q.push_back('{0, c, (1 << (rem < LANES ? rem : LANES)) - 1});
            nb++;
            c = op ? c + LANES : (c > LANES ? c - LANES : 0);
        end
        aborted = abort_at >= 0 && abort_at < nb;
        if (!aborted) q.push_back('{1, 0, 0});
        @(posedge clk); #1;
        start = 1'b1; vector_len = N'(len); op_type = op;
        @(posedge clk); #1;
        start = 1'b0;
        stall = pct > 0 && $urandom_range(99) < pct;
        abort = aborted && abort_at == 0;
        @(negedge clk);
        chk("finished_after_start", int'(o_finished), int'(len == 0));
        chk("busy_after_start", int'(o_busy), int'(len != 0));
        while (o_busy && cyc < 600) begin
            cyc++;
            if (stall && !abort) stc++;
            if (!stall && !abort) acc++;
            @(posedge clk); #1;
            stall = pct > 0 && $urandom_range(99) < pct;
            abort = aborted && acc == abort_at && o_busy;
            @(negedge clk);
        end
        stall = 1'b0;
        abort = 1'b0;
        if (cyc >= 600) unexpected("run_timeout");
        if (aborted) begin
            chk("abort_counter", int'(o_counter), 0);
            chk("abort_finished", int'(o_finished), 0);
            chk("abort_mask", int'(o_lane_mask), 0);
            chk("abort_valid", int'(o_beat_valid), 0);
        end else begin
            chk("run_cycles", cyc, nb + stc);
            chk("finished_set", int'(o_finished), 1);
            if (use_ack) begin
                @(posedge clk); #1 ack = 1'b1;
                @(posedge clk); #1 ack = 1'b0;
                @(negedge clk);
                chk("ack_finished", int'(o_finished), 0);
                chk("ack_busy", int'(o_busy), 0);
                chk("ack_counter", int'(o_counter), 0);
            end
        end
        @(posedge clk); #1;
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic reset_mid_run();
        q.push_back('{0, 0, 15});
        q.push_back('{0, 4, 15});
        @(posedge clk); #1;
        start = 1'b1; vector_len = N'(20); op_type = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_counter", int'(o_counter), 8);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_counter", int'(o_counter), 0);
        chk("rst_valid", int'(o_beat_valid), 0);
        chk("rst_mask", int'(o_lane_mask), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_queue", q.size(), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_finished", int'(o_finished), 0);
            chk("post_rst_busy", int'(o_busy), 0);
        end
    endtask

    initial begin
        #3;
        chk("reset_counter", int'(o_counter), 0);
        chk("reset_valid", int'(o_beat_valid), 0);
        chk("reset_mask", int'(o_lane_mask), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_finished", int'(o_finished), 0);
        chk("reset_done_pulse", int'(o_done_pulse), 0);
        #9 rst_n = 1'b1;
        run_op(10, 1'b1, -1, 1'b1, 0);
        run_op(10, 1'b0, -1, 1'b1, 0);
        run_op(0, 1'b1, -1, 1'b1, 0);
        run_op(12, 1'b1, -1, 1'b1, 50);
        run_op(63, 1'b1, -1, 1'b0, 0);
        run_op(5, 1'b1, -1, 1'b0, 20);
        run_op(0, 1'b0, -1, 1'b0, 0);
        run_op(20, 1'b1, 2, 1'b0, 30);
        run_op(63, 1'b0, -1, 1'b1, 25);
        reset_mid_run();
        for (int k = 0; k < 30; k++)
            run_op($urandom_range(0, 63), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) == 0 ? $urandom_range(0, 6) : -1,
                   1'($urandom_range(0, 1)), $urandom_range(0, 50));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vector_finish_tracker.md
VECTOR_FINISH_TRACKER -- requirements
Module: vector_finish_tracker

Interface
REQ-001 Parameter N, default 6: element-count / counter width; vector length range 0..2^N-1.
REQ-002 Parameter LANES, default 4: elements processed per beat; power of two, 1..16.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a vector operation.
REQ-006 vector_len  in  N  element count, sampled when start is accepted.
REQ-007 op_type  in  1  1 = count up from 0 to vector_len; 0 = count down from vector_len; sampled with start.
REQ-008 stall  in  1  downstream not ready; current beat held.
REQ-009 abort  in  1  synchronous cancel of the running operation.
REQ-010 ack  in  1  consumer acknowledge; clears finished.
REQ-011 counter  out  N  current element position (next-element index up; remaining count down).
REQ-012 beat_valid  out  1  a beat is presented this cycle.
REQ-013 lane_mask  out  LANES  valid lanes of current beat; bit i = lane i.
REQ-014 busy  out  1  high in RUN.
REQ-015 finished  out  1  sticky completion flag.
REQ-016 done_pulse  out  1  one-cycle pulse coinciding with finished rising.

Function
REQ-017 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-018 IDLE: start with vector_len != 0 -> RUN; start with vector_len == 0 -> DONE (no beats issued).
REQ-019 RUN entry: counter = 0 (op_type 1) or counter = vector_len (op_type 0); first beat_valid the cycle after start.
REQ-020 beat_valid = 1 throughout RUN; beat accepted when beat_valid && !stall.
REQ-021 remaining = vector_len - counter (up) or counter (down); lane_mask bit i = 1 iff i < min(LANES, remaining).
REQ-022 On accepted beat: counter += LANES (up) or -= LANES (down), saturating at vector_len (up) / 0 (down).
REQ-023 Up-mode arithmetic in N+1 bits; counter never wraps, including vector_len = 2^N-1.
REQ-024 Accepted beat with remaining <= LANES is last: next state DONE; finished and done_pulse high the following cycle.
REQ-025 stall high: counter, lane_mask and state unchanged; stall ignored outside RUN.
REQ-026 abort in RUN -> IDLE next cycle, finished stays 0, no done_pulse; abort outside RUN ignored; abort beats stall and last-beat acceptance.
REQ-027 start while in RUN ignored.
REQ-028 DONE: finished held 1 until leave; ack -> IDLE, finished 0 next cycle.
REQ-029 DONE with start (with or without ack): treated as new request per REQ-018/019; finished cleared next cycle unless new vector_len == 0 (re-enters DONE, done_pulse fires again).
REQ-030 done_pulse high only on the cycle of entry to DONE.
REQ-031 Outside RUN: beat_valid 0, lane_mask 0.

Reset
REQ-032 rst low asynchronously forces IDLE, counter 0, beat_valid 0, lane_mask 0, busy 0, finished 0, done_pulse 0, latched len/op_type 0.
REQ-033 Reset mid-RUN discards the operation; no done_pulse after release.
REQ-034 First state change after rst release no earlier than first rising edge with rst high.

Structure
REQ-035 Shared vector package holds state enum type, op_type encodings (OP_DOWN=0, OP_UP=1), default N and LANES.
REQ-036 One sub-module, lane_mask_gen: combinational remaining-count to thermometer mask.

Verification (N=6, LANES=4)
REQ-037 Up, len=10 -> beats counter 0,4,8 masks 1111,1111,0011; finished+done_pulse cycle after third beat.
REQ-038 Down, len=10 -> counter 10,6,2 masks 1111,1111,0011; finished after third beat; ack -> IDLE next cycle.
REQ-039 len=0 start -> no beat_valid; finished+done_pulse 1 cycle after start.
REQ-040 Up, len=12, stall high 3 cycles on beat 2 -> counter held at 4 for 3 cycles; finished 3 cycles later than unstalled.
REQ-041 Up, len=63 -> 16 beats, last counter 60 mask 0111, no wrap; then start in DONE len=5 -> finished drops, restart.
REQ-042 abort on beat 2, and separately rst low on beat 2 -> IDLE, outputs zero, finished never asserted.
